// File: rtl/led_arbiter.sv
// led_arbiter: shares one status LED among NUM_REQ requesters using fixed priority, a minimum hold and blink patterns.
// Optional build macro LED_ARB_PREEMPT_EN: higher-priority requests take the LED at once, ignoring the hold time.
module led_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int CLK_HZ          = 12000000,
   parameter int TICK_HZ         = 1000,
   parameter int MIN_HOLD_TICKS  = 500,
   parameter int SLOW_HALF_TICKS = 500,
   parameter int FAST_HALF_TICKS = 125
) (
   input  logic                   clk_12mhz,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [2*NUM_REQ-1:0]   pattern,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   led,
   output logic                   busy
);

   localparam int PRESC_DIV = CLK_HZ / TICK_HZ;
   localparam int PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam int HOLD_W    = $clog2(MIN_HOLD_TICKS + 1);
   localparam int HALF_MAX  = (SLOW_HALF_TICKS > FAST_HALF_TICKS) ? SLOW_HALF_TICKS : FAST_HALF_TICKS;
   localparam int PHASE_W   = ($clog2(HALF_MAX) > 0) ? $clog2(HALF_MAX) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(MIN_HOLD_TICKS);
   localparam logic [PHASE_W-1:0] SLOW_LAST  = PHASE_W'(SLOW_HALF_TICKS - 1);
   localparam logic [PHASE_W-1:0] FAST_LAST  = PHASE_W'(FAST_HALF_TICKS - 1);

   localparam logic [1:0] PAT_OFF  = 2'b00;
   localparam logic [1:0] PAT_ON   = 2'b01;
   localparam logic [1:0] PAT_SLOW = 2'b10;
   localparam logic [1:0] PAT_FAST = 2'b11;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Isolates the lowest set bit, i.e. the highest-priority requester.
   function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] v);
      return v & (~v + NUM_REQ'(1));
   endfunction

   function automatic logic [1:0] field_of(input logic [2*NUM_REQ-1:0] pat,
                                           input logic [NUM_REQ-1:0]   sel);
      logic [1:0] f;
      f = 2'b00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel[i]) begin
            f = f | pat[2*i +: 2];
         end else begin
            f = f;
         end
      end
      return f;
   endfunction

   state_t               state_r, state_s;
   logic [NUM_REQ-1:0]   gnt_r, gnt_s;
   logic                 busy_r;
   logic                 led_r, led_s;
   logic [PRESC_W-1:0]   presc_r;
   logic                 tick_s;
   logic [HOLD_W-1:0]    hold_r, hold_s;
   logic [PHASE_W-1:0]   phase_r, phase_s;
   logic                 blink_r, blink_s;
   logic [1:0]           pat_prev_r, pat_next_s;
   logic [1:0]           owner_pat_s;
   logic [NUM_REQ-1:0]   first_s;
   logic [NUM_REQ-1:0]   higher_s;
   logic                 owner_req_s;
   logic                 hold_gate_s;
   logic [PHASE_W-1:0]   half_last_s;

   assign tick_s      = (presc_r == PRESC_LAST);
   assign owner_pat_s = field_of(pattern, gnt_r);
   assign first_s     = lowest_onehot(req);
   // Bits below the one-hot owner are exactly the higher-priority requesters.
   assign higher_s    = req & (gnt_r - NUM_REQ'(1));
   assign owner_req_s = ((req & gnt_r) != {NUM_REQ{1'b0}});
   assign half_last_s = (owner_pat_s == PAT_FAST) ? FAST_LAST : SLOW_LAST;
   assign pat_next_s  = field_of(pattern, gnt_s);

`ifdef LED_ARB_PREEMPT_EN
   assign hold_gate_s = 1'b1;
`else
   assign hold_gate_s = (hold_r == {HOLD_W{1'b0}});
`endif

   // Free-running timebase prescaler; never disturbed by arbitration.
   always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PRESC_W{1'b0}};
      end else if (tick_s) begin
         presc_r <= {PRESC_W{1'b0}};
      end else begin
         presc_r <= presc_r + PRESC_W'(1);
      end
   end

   // Arbitration, hold countdown and blink phase next-state logic.
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      hold_s  = hold_r;
      phase_s = phase_r;
      blink_s = blink_r;
      case (state_r)
         ST_IDLE: begin
            if (req != {NUM_REQ{1'b0}}) begin
               state_s = ST_GRANT;
               gnt_s   = first_s;
               hold_s  = HOLD_LOAD;
               phase_s = {PHASE_W{1'b0}};
               blink_s = 1'b1;
            end else begin
               gnt_s   = {NUM_REQ{1'b0}};
            end
         end
         ST_GRANT: begin
            if (!owner_req_s) begin
               // Owner drop wins over any pending higher request.
               state_s = ST_IDLE;
               gnt_s   = {NUM_REQ{1'b0}};
            end else if ((higher_s != {NUM_REQ{1'b0}}) && hold_gate_s) begin
               gnt_s   = first_s;
               hold_s  = HOLD_LOAD;
               phase_s = {PHASE_W{1'b0}};
               blink_s = 1'b1;
            end else begin
               if (tick_s && (hold_r != {HOLD_W{1'b0}})) begin
                  hold_s = hold_r - HOLD_W'(1);
               end else begin
                  hold_s = hold_r;
               end
               if (owner_pat_s != pat_prev_r) begin
                  phase_s = {PHASE_W{1'b0}};
                  blink_s = 1'b1;
               end else if (tick_s && owner_pat_s[1]) begin
                  if (phase_r >= half_last_s) begin
                     phase_s = {PHASE_W{1'b0}};
                     blink_s = ~blink_r;
                  end else begin
                     phase_s = phase_r + PHASE_W'(1);
                     blink_s = blink_r;
                  end
               end else begin
                  phase_s = phase_r;
                  blink_s = blink_r;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // LED drive decoded from the current grant, live pattern and blink phase.
   always_comb begin
      led_s = 1'b0;
      if (state_r == ST_GRANT) begin
         case (owner_pat_s)
            PAT_OFF:            led_s = 1'b0;
            PAT_ON:             led_s = 1'b1;
            PAT_SLOW, PAT_FAST: led_s = blink_r;
            default:            led_s = 1'b0;
         endcase
      end else begin
         led_s = 1'b0;
      end
   end

   // State, grant, counters and output registers.
   always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         gnt_r      <= {NUM_REQ{1'b0}};
         busy_r     <= 1'b0;
         led_r      <= 1'b0;
         hold_r     <= {HOLD_W{1'b0}};
         phase_r    <= {PHASE_W{1'b0}};
         blink_r    <= 1'b0;
         pat_prev_r <= 2'b00;
      end else begin
         state_r    <= state_s;
         gnt_r      <= gnt_s;
         busy_r     <= (state_s == ST_GRANT);
         led_r      <= led_s;
         hold_r     <= hold_s;
         phase_r    <= phase_s;
         blink_r    <= blink_s;
         pat_prev_r <= pat_next_s;
      end
   end

   assign gnt  = gnt_r;
   assign led  = led_r;
   assign busy = busy_r;

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares a single status LED among NUM_REQ requesters.
- Each requester asks for the LED with a display pattern: off, on, slow blink or fast blink.
- Fixed priority arbitration (index 0 highest) with a minimum hold time so the LED does not flicker between owners.
- Blink timing comes from a prescaled tick on the board's 12 MHz clock; instantiate once per LED (led7, led8).

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- CLK_HZ, 12000000: clk_12mhz frequency; must be an integer multiple of TICK_HZ.
- TICK_HZ, 1000: timebase tick rate.
- MIN_HOLD_TICKS, 500: minimum ticks a grant is held against higher-priority requests; at least 1.
- SLOW_HALF_TICKS, 500: half-period of slow blink, in ticks; at least 1.
- FAST_HALF_TICKS, 125: half-period of fast blink, in ticks; at least 1.

Ports:
- clk_12mhz  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester; level, held while LED wanted.
- pattern  in  2*NUM_REQ  per-requester pattern; field i = pattern[2i+1:2i]; 00 off, 01 on, 10 slow, 11 fast.
- gnt  out  NUM_REQ  registered one-hot grant, or all zero.
- led  out  1  registered LED drive, active high.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset is asynchronous: gnt=0, led=0, busy=0, state=IDLE, and the prescaler, hold counter and phase counter are all 0. Assertion mid-grant clears every output immediately, without waiting for a clock edge.
- Prescaler counts 0..CLK_HZ/TICK_HZ-1. Internal tick is a one-cycle pulse on the wrap. The prescaler free-runs and is never reset by grants.
- State IDLE: on an edge where req!=0, gnt takes the lowest set index and state goes to GRANT. On the same edge, hold=MIN_HOLD_TICKS, phase counter=0, blink_phase=1.
- State GRANT, owner deasserts req: gnt=0 and state=IDLE on the next edge, regardless of hold. led=0 one edge later. Result is a one-cycle IDLE gap before any new grant.
- State GRANT, owner still requesting: hold decrements on each tick and saturates at 0.
- Higher-priority switch: if a higher-priority req is set and hold==0, gnt moves directly to the highest-priority requester on the next edge. hold, phase counter and blink_phase reload as in IDLE. No IDLE cycle occurs.
- Lower-priority requests never displace the owner.
- Simultaneous owner drop and higher request: the owner drop wins, giving IDLE for one cycle, then normal arbitration.
- The owner's pattern field is sampled live every cycle, not latched at grant.
- Pattern change during a grant: phase counter=0 and blink_phase=1 on the next edge. A registered copy of the previous field is used to detect the change.
- Blink: the phase counter increments on tick. When it reaches HALF-1 (SLOW or FAST per the pattern), it wraps to 0 and blink_phase toggles. Phase is tick-aligned, so the first half-period may be short by up to one tick.
- led output, registered one cycle after gnt/pattern:
  - in IDLE: 0.
  - 00: 0.
  - 01: 1.
  - 10 and 11: blink_phase.
- busy = (state==GRANT), registered together with gnt.
- Widths: hold uses $clog2(MIN_HOLD_TICKS+1) bits. The phase counter uses $clog2(max(SLOW,FAST)) bits, minimum 1. All counters are unsigned, with no wrap past their terminal value.

Optional Feature:
- Macro: LED_ARB_PREEMPT_EN.
- Defined: a higher-priority request preempts on the next edge even when hold!=0. Reload behaviour is identical to a normal switch. hold still counts but gates nothing.
- Undefined: the hold rule above applies.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=1000, TICK_HZ=100 (10 clk per tick), MIN_HOLD_TICKS=5, SLOW_HALF_TICKS=3, FAST_HALF_TICKS=1, NUM_REQ=4.
- Reset: rst_n=0 with req=1111 -> gnt=0000, led=0, busy=0. Release rst_n -> gnt=0001 and busy=1 at the first edge; led reflects pattern[1:0] at the second edge.
- Solid: only req[2]=1, pattern field 2 = 01 -> gnt=0100 after 1 clk, led=1 after 2 clk, and led stays 1 for 200 clk.
- Slow blink: req[1], pattern field 1 = 10 -> led toggles every 30 clk after the first, possibly short, half-period. Change the field to 11 mid-grant -> led=1 next edge, then toggles every 10 clk.
- Hold: req[3] granted; req[0] rises 10 clk later -> gnt stays 1000 until 5 ticks have elapsed since grant, then 0001 on the next edge with no zero cycle.
- Owner drop: owner deasserts req with a lower request pending -> gnt=0000 and led=0 for exactly one cycle, then the lower requester is granted.
- LED_ARB_PREEMPT_EN defined, hold scenario -> gnt=0001 one edge after req[0] rises. Async reset pulse mid-grant -> gnt=0 and led=0 before the next clock edge.
